// File: rtl/uart_rx_parity_pkg.sv
// Shared UART receive types: FSM state encoding and oversampling constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;
  localparam int LAST_TICK  = 15;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_rx_parity_if.sv
// Receive-side bus from the UART receiver towards the RX FIFO write port.
// Latency: wires only.
// Backpressure: none; the consumer must accept every rx_done strobe.
interface uart_rx_parity_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  parity_err;
  logic                  frame_err;
  logic                  rx_busy;

  modport master (
    output rx_data,
    output rx_done,
    output parity_err,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_done,
    input parity_err,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/uart_rx_parity_baud_tick.sv
// Oversample tick divider: one-cycle tick every DVSR clocks, held at zero by clr.
// Latency: first tick DVSR cycles after clr drops.
// Backpressure: none.
module uart_baud_tick #(
  parameter int DVSR = 4
) (
  input  logic UCLK,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Divider counter: restarts on clear and on every wrap.
  always_ff @(posedge UCLK) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver, 16x oversampled; optional parity stage built when UART_RX_PARITY_EN is defined.
// Latency: ~3 + (8 + 16*(DATA_WIDTH+P) + 16)*DVSR cycles from start-bit fall to rx_done.
// Backpressure: none; rx_done is a one-cycle strobe that cannot be stalled.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR       = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              UCLK,
  input  logic              reset,
  input  logic              rx,
  uart_rx_parity_if.master  rx_if
);

  localparam int                NW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [NW-1:0]     N_LAST = NW'(DATA_WIDTH - 1);
  localparam logic [TICK_W-1:0] S_MID  = TICK_W'(MID_START);
  localparam logic [TICK_W-1:0] S_LAST = TICK_W'(LAST_TICK);

  logic                  rx_m, rx_s;
  logic                  tick;
  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fe_q, fe_d;
  logic                  done_q, done_d;
  logic                  busy_q;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic perr_q, perr_d;
  logic pe_q, pe_d;
`endif

  // Two-flop synchronizer; resets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge UCLK) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Tick phase is aligned to the detected falling edge by holding the divider in IDLE.
  uart_baud_tick #(.DVSR(DVSR)) u_baud_tick (
    .UCLK  (UCLK),
    .reset (reset),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  // State, counters and registered outputs.
  always_ff @(posedge UCLK) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      fe_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      fe_q    <= fe_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Next-state logic: every action happens on a tick at the bit-centre sample point.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    fe_d    = fe_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            // A start bit that has gone high by its centre is treated as a glitch.
            state_d = rx_s ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
            s_d     = '0;
            n_d     = n_q + 1'b1;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            perr_d  = ((^shreg_q) ^ rx_s) != PAR_ODD;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            data_d  = shreg_q;
            fe_d    = ~rx_s;
            done_d  = 1'b1;
            s_d     = '0;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            pe_d    = perr_q;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_done   = done_q;
  assign rx_if.frame_err = fe_q;
  assign rx_if.rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = pe_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity: randomized and directed frames, reference model in the bench.
// Stimulus pushes expected bytes/flags; a negedge monitor pops and compares on every rx_done.
module tb_uart_rx_parity;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DVSR       = 4;
  localparam int PARITY_ODD = 0;
  localparam int BIT        = 16 * DVSR;
  localparam int FRAME      = BIT * (10 + P);
  localparam int LAT_MIN    = (8 + 16 * (8 + P) + 16) * DVSR;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;
  } exp_t;

  logic UCLK = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   last_done = 0;
  int   prev_done = 0;
  exp_t exp_q[$];

  uart_rx_parity_if #(.DATA_WIDTH(8)) u_if ();

  uart_rx_parity #(
    .DATA_WIDTH (8),
    .DVSR       (DVSR),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .UCLK  (UCLK),
    .reset (reset),
    .rx    (rx),
    .rx_if (u_if)
  );

  initial forever #5 UCLK = ~UCLK;
  initial forever begin
    @(posedge UCLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Parity bit a correct transmitter would send: total ones even (or odd for PARITY_ODD).
  function automatic logic par_bit(input logic [7:0] d, input logic bad);
    return logic'((($countones(d) + PARITY_ODD) % 2) == 1) ^ bad;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge UCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad, input logic stop);
    exp_t       e;
    logic [10:0] bits;
    int         nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    nb        = 10 + P;
    if (P == 1) begin
      bits[9]  = par_bit(d, bad);
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    e.d  = d;
    e.pe = (P == 1) ? bad : 1'b0;
    e.fe = ~stop;
    e.t0 = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (BIT) @(negedge UCLK);
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge UCLK);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, u_if.rx_data, 0);
    check({tag, "_done"}, u_if.rx_done, 0);
    check({tag, "_perr"}, u_if.parity_err, 0);
    check({tag, "_ferr"}, u_if.frame_err, 0);
    check({tag, "_busy"}, u_if.rx_busy, 0);
  endtask

  // Monitor: every rx_done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge UCLK);
      if (u_if.rx_done === 1'b1) begin
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got rx_done=1 data=%0h, required no pulse (cycle %0d)",
                   u_if.rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", u_if.rx_data, e.d);
          check("parity_err", u_if.parity_err, e.pe);
          check("frame_err", u_if.frame_err, e.fe);
          if (e.t0 >= 0) begin
            lat = cyc - e.t0;
            n_cmp++;
            if (lat < LAT_MIN || lat > LAT_MIN + 3) begin
              n_err++;
              $display("FAIL latency: got %0d, required %0d..%0d", lat, LAT_MIN, LAT_MIN + 3);
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    wait (cyc > 90000);
    $display("FAIL watchdog: got cycle %0d, required completion earlier", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int   bad;
    int   t;
    int   d0;
    exp_t e;
    logic [7:0] rd;
    logic rbad, rstop;
    int   gap;

    // Reset and quiet idle line.
    reset = 1'b0;
    rx    = 1'b1;
    repeat (10) @(negedge UCLK);
    reset = 1'b1;
    check_reset_outputs("rst");
    bad = 0;
    repeat (1000) begin
      @(negedge UCLK);
      if (u_if.rx_done !== 1'b0 || u_if.rx_busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check_reset_outputs("idle");

    // Clean frame, bad parity, framing error then recovery.
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(50);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(50);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    send_frame(8'h01, 1'b0, 1'b1);
    wait_drain("drain_directed", 2000);

    // Short glitch on the line is rejected.
    d0 = done_cnt;
    t  = cyc;
    rx = 1'b0;
    repeat (10) @(negedge UCLK);
    check("glitch_busy_hi", u_if.rx_busy, 1);
    repeat (6) @(negedge UCLK);
    rx = 1'b1;
    repeat (24) @(negedge UCLK);
    check("glitch_cycle", cyc - t, 40);
    check("glitch_busy_lo", u_if.rx_busy, 0);
    idle(800);
    check("glitch_no_done", done_cnt - d0, 0);

    // Back-to-back frames are spaced by exactly one frame time.
    send_frame(8'hAA, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_drain("drain_b2b", 2000);
    check("b2b_spacing", last_done - prev_done, FRAME);

    // Reset in the middle of a frame discards it.
    d0 = done_cnt;
    rx = 1'b0;
    repeat (BIT) @(negedge UCLK);
    for (int i = 0; i < 4; i++) begin
      rd = 8'hAA;
      rx = rd[i];
      repeat (BIT) @(negedge UCLK);
    end
    reset = 1'b0;
    rx    = 1'b1;
    repeat (10) @(negedge UCLK);
    reset = 1'b1;
    check_reset_outputs("midrst");
    idle(800);
    check("midrst_no_done", done_cnt - d0, 0);
    send_frame(8'h0F, 1'b0, 1'b1);
    wait_drain("drain_midrst", 2000);

    // Break: two all-zero frames with framing error, then released before a third.
    d0   = done_cnt;
    e.d  = 8'h00;
    e.pe = (P == 1) ? logic'(PARITY_ODD != 0) : 1'b0;
    e.fe = 1'b1;
    e.t0 = cyc;
    exp_q.push_back(e);
    e.t0 = -1;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (2 * LAT_MIN + 16) @(negedge UCLK);
    idle(300);
    wait_drain("drain_break", 100);
    check("break_frames", done_cnt - d0, 2);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_drain("drain_after_break", 2000);

    // Randomized frames with random gaps, parity faults and stop faults.
    for (int k = 0; k < 12; k++) begin
      rd    = 8'($urandom_range(0, 255));
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      gap   = rstop ? $urandom_range(0, 80) : $urandom_range(64, 120);
      send_frame(rd, rbad, rstop);
      idle(gap);
    end
    wait_drain("drain_random", 2000);

    idle(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

- Serial-to-parallel UART receiver, the receive end of the team's UART link.
- Recovers 8N1/8E1-style frames from a single asynchronous `rx` line using 16x oversampling and an internal baud-tick divider.
- Checks the optional parity bit and the stop bit, then presents each byte with a one-cycle `rx_done` strobe and sticky-per-frame error flags.
- Sits between the pad and the RX FIFO write port.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first.
- `DVSR`, 4: `UCLK` cycles per oversample tick (≥1). Bit period = 16·DVSR cycles.
- `PARITY_ODD`, 0: 0 = even parity expected, 1 = odd.
- `UCLK` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `rx` in 1: asynchronous serial line, idle high.
- `rx_data` out DATA_WIDTH: last received byte.
- `rx_done` out 1: one-cycle pulse when `rx_data` and the error flags update.
- `parity_err` out 1: parity mismatch in the last frame.
- `frame_err` out 1: stop bit sampled low in the last frame.
- `rx_busy` out 1: high whenever state ≠ IDLE.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized `rx_s`.
- **Tick generator:** counts 0..DVSR-1 and pulses `tick` on wrap. It is held at 0 in IDLE and free-runs in all other states.
- **Counters:** `s` (0..15) counts ticks within a bit; `n` counts data bits; `shreg` is the shift register.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rx_s` = 0, go to START with `s` = 0.
  - START: on the tick with `s` = 7 (mid start bit), if `rx_s` = 0 go to DATA with `s` = 0, `n` = 0. Otherwise return to IDLE silently (glitch reject: no `rx_done`, flags unchanged).
  - DATA: on the tick with `s` = 15, set `shreg` = {`rx_s`, `shreg[DW-1:1]`}, `s` = 0, `n`++. After the sample with `n` = DATA_WIDTH-1, go to PARITY (macro defined) or STOP.
  - PARITY: on the tick with `s` = 15, capture `p`; `perr` = (^`shreg` ^ `p`) ≠ PARITY_ODD. Go to STOP.
  - STOP: on the tick with `s` = 15 (mid stop bit), load `rx_data` ← `shreg`, `parity_err` ← `perr`, `frame_err` ← ~`rx_s`, and pulse `rx_done`. Go to IDLE.
- **Error handling:** `rx_data` loads even when a frame has errors. Flags hold until the next `rx_done`.
- **Back-to-back frames:** the return to IDLE at mid stop bit allows the next start bit to be detected with no idle gap.
- **Break (line held low):** each frame ends with `frame_err` = 1 and `rx_data` = 0, and the receiver re-enters START immediately.
- **Reset while low:** all registers clear, the FSM goes to IDLE and the synchronizer to 1. A frame in progress is discarded with no `rx_done`.

## Timing
- **Reset values:** `rx_data` = 0, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0, `rx_busy` = 0.
- **Latency:** 2-cycle synchronizer, plus detection cycle, plus (8 + 16·(DATA_WIDTH + P) + 16)·DVSR cycles from the falling edge of `rx` to `rx_done`, where P = 1 with parity and 0 without. Defaults with parity give 672 cycles, +3/−0.
- **Outputs:** all registered. `rx_done` is high for exactly one `UCLK` cycle, and `rx_data` and the flags are valid in that same cycle.
- **Tolerance:** sampling point lies within ±1 tick of bit centre, so ±4 % baud mismatch is tolerated.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state is present, frame is start + data + parity + stop, and `parity_err` is computed as above.
- Macro undefined: PARITY state is compiled out, DATA goes directly to STOP, and `parity_err` is tied to 0.

## Structure
- `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE` = 16;
  - `MID_START` = 7;
  - `LAST_TICK` = 15.
- Sub-module `uart_baud_tick`: a parameterised DVSR divider with a synchronous clear input, reusable by the transmitter.

## Test plan
Bit period is 64 cycles (DVSR = 4). Build with `UART_RX_PARITY_EN` unless stated.
1. Reset held low 10 cycles with `rx` = 1, then released and idle for 1000 cycles → all outputs 0, no `rx_done`, `rx_busy` = 0.
2. Frame 0xAA with parity bit 0 and stop bit 1 → single `rx_done` pulse within 672..675 cycles; `rx_data` = 0xAA, `parity_err` = 0, `frame_err` = 0.
3. Frame 0x55 with parity bit 1 (wrong) → `rx_data` = 0x55, `parity_err` = 1, `frame_err` = 0.
4. Frame 0x3C with correct parity and stop bit 0 → `rx_data` = 0x3C, `frame_err` = 1. The next clean frame 0x01 clears both flags.
5. `rx` low for 16 cycles then high → `rx_busy` returns to 0 before cycle 40, no `rx_done`.
6. 0xAA immediately followed by 0x55 → two `rx_done` pulses 704 cycles apart with correct data. Reset asserted mid-frame on a third frame → no `rx_done`. A following 0x0F frame is received correctly.
